// File: rtl/pixel_window_pkg.sv
// Shared types and helpers for the 3x3 pixel window block.
package pixel_window_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int MAX_X_DEF = 4096;
  localparam int YW_DEF    = 12;

  function automatic int calc_xw(input int max_x);
    return $clog2(max_x + 32'sd1);
  endfunction

  localparam int XW_DEF = calc_xw(MAX_X_DEF);

  typedef struct packed {
    logic [XW_DEF-1:0] x;
    logic [YW_DEF-1:0] y;
  } coord_t;

  typedef logic [PIX_W_DEF-1:0] window_t [3][3];

endpackage

// File: rtl/line_ram.sv
// Single-port line store holding {row y-2, row y-1} per column.
// Asynchronous read, synchronous write; contents are never reset.
module line_ram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 16,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port; the asynchronous read sees the old word during the write cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/pixel_window_3x3.sv
// Streaming 3x3 window generator over a raster pixel stream.
// Emits a window only when it lies entirely inside the image.
module pixel_window_3x3
  import pixel_window_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int MAX_X = 4096,
  parameter int XW    = calc_xw(MAX_X),
  parameter int YW    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XW-1:0]    size_x,
  input  logic             sof,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] pixel_mp,
  output logic [PIX_W-1:0] pixel_0p,
  output logic [PIX_W-1:0] pixel_pp,
  output logic [PIX_W-1:0] pixel_m0,
  output logic [PIX_W-1:0] pixel_00,
  output logic [PIX_W-1:0] pixel_p0,
  output logic [PIX_W-1:0] pixel_mm,
  output logic [PIX_W-1:0] pixel_0m,
  output logic [PIX_W-1:0] pixel_pm,
  output logic [XW-1:0]    out_x,
  output logic [YW-1:0]    out_y,
  output logic             cfg_err
);

  localparam int AW = (MAX_X > 1) ? $clog2(MAX_X) : 1;

  logic [XW-1:0]      col_r;
  logic [YW-1:0]      row_r;
  logic [XW-1:0]      size_r;
  logic               armed_r;
  logic               cfg_err_r;
  logic               out_valid_r;
  logic [XW-1:0]      out_x_r;
  logic [YW-1:0]      out_y_r;
  logic [PIX_W-1:0]   win_r [3][3];

  logic               in_ready_s;
  logic               accept_s;
  logic               size_ok_s;
  logic               run_s;
  logic               process_s;
  logic               qualify_s;
  logic               last_col_s;
  logic [XW-1:0]      eff_col_s;
  logic [YW-1:0]      eff_row_s;
  logic [XW-1:0]      eff_size_s;
  logic [AW-1:0]      ram_addr_s;
  logic [2*PIX_W-1:0] ram_rd_s;
  logic [2*PIX_W-1:0] ram_wd_s;

  // An accepted sof pixel is treated as (0,0) of the new frame in the same cycle.
  always_comb begin
    in_ready_s = ~out_valid_r | out_ready;
    accept_s   = in_valid & in_ready_s;
    size_ok_s  = (size_x >= XW'(3)) && (size_x <= XW'(MAX_X));
    if (sof) begin
      eff_col_s  = {XW{1'b0}};
      eff_row_s  = {YW{1'b0}};
      eff_size_s = size_x;
      run_s      = size_ok_s;
    end else begin
      eff_col_s  = col_r;
      eff_row_s  = row_r;
      eff_size_s = size_r;
      run_s      = armed_r;
    end
    process_s  = accept_s & run_s;
    qualify_s  = process_s && (eff_col_s >= XW'(2)) && (eff_row_s >= YW'(2));
    last_col_s = (eff_col_s == (eff_size_s - XW'(1)));
    ram_addr_s = eff_col_s[AW-1:0];
  end

  // Row y-1 moves into the y-2 slot while the new pixel becomes row y-1.
  assign ram_wd_s = {ram_rd_s[PIX_W-1:0], pixel_in};

  line_ram #(
    .DEPTH (MAX_X),
    .WIDTH (2*PIX_W),
    .AW    (AW)
  ) u_line_ram (
    .clk   (clk),
    .we    (process_s),
    .addr  (ram_addr_s),
    .wdata (ram_wd_s),
    .rdata (ram_rd_s)
  );

  // Frame arming, size capture, configuration check and raster position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_r     <= {XW{1'b0}};
      row_r     <= {YW{1'b0}};
      size_r    <= {XW{1'b0}};
      armed_r   <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      if (accept_s && sof) begin
        armed_r   <= size_ok_s;
        cfg_err_r <= ~size_ok_s;
        size_r    <= size_x;
      end
      if (process_s) begin
        if (last_col_s) begin
          col_r <= {XW{1'b0}};
          row_r <= (eff_row_s == {YW{1'b1}}) ? eff_row_s : eff_row_s + YW'(1);
        end else begin
          col_r <= eff_col_s + XW'(1);
          row_r <= eff_row_s;
        end
      end else if (accept_s && sof) begin
        col_r <= {XW{1'b0}};
        row_r <= {YW{1'b0}};
      end
    end
  end

  // Sliding window: shift left, new right column is {row y-2, row y-1, row y}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_r[r][c] <= {PIX_W{1'b0}};
        end
      end
    end else if (process_s) begin
      for (int r = 0; r < 3; r++) begin
        win_r[r][0] <= win_r[r][1];
        win_r[r][1] <= win_r[r][2];
      end
      win_r[0][2] <= ram_rd_s[2*PIX_W-1:PIX_W];
      win_r[1][2] <= ram_rd_s[PIX_W-1:0];
      win_r[2][2] <= pixel_in;
    end
  end

  // Output stage: one register slice, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_x_r     <= {XW{1'b0}};
      out_y_r     <= {YW{1'b0}};
    end else if (qualify_s) begin
      out_valid_r <= 1'b1;
      out_x_r     <= eff_col_s - XW'(1);
      out_y_r     <= eff_row_s - YW'(1);
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_x     = out_x_r;
  assign out_y     = out_y_r;
  assign cfg_err   = cfg_err_r;
  assign pixel_mp  = win_r[0][0];
  assign pixel_0p  = win_r[0][1];
  assign pixel_pp  = win_r[0][2];
  assign pixel_m0  = win_r[1][0];
  assign pixel_00  = win_r[1][1];
  assign pixel_p0  = win_r[1][2];
  assign pixel_mm  = win_r[2][0];
  assign pixel_0m  = win_r[2][1];
  assign pixel_pm  = win_r[2][2];

endmodule
